// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a 16-bit word-count header from a byte
// stream, assembles big-endian 32-bit words and writes them while holding the CPU stalled.
`timescale 1ns/1ps

module imem_loader #(
   parameter int unsigned DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_we,
   output logic [31:0] im_waddr,
   output logic [31:0] im_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_e;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   state_e      state_q, state_d;
   logic [15:0] count_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] asm_q;
   logic        im_we_q;
   logic [31:0] im_waddr_q;
   logic [31:0] im_wdata_q;
   logic [15:0] words_loaded_q;

   logic        xfer;
   logic        start_ok;
   logic [15:0] hdr_count;
   logic [15:0] words_next;

   assign xfer       = in_valid && in_ready;
   assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
   assign hdr_count  = {count_q[15:8], in_data};
   assign words_next = words_loaded_q + 16'd1;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_HDR0;
         end
         S_HDR0: begin
            if (xfer) state_d = S_HDR1;
         end
         S_HDR1: begin
            if (xfer) begin
               if (hdr_count == 16'd0)         state_d = S_DONE;
               else if (hdr_count > DEPTH_W)   state_d = S_ERR;
               else                            state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && byte_idx_q == 2'd3) state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = (words_next == count_q) ? S_DONE : S_DATA;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
      cpu_hold = (state_q != S_DONE);
      done     = (state_q == S_DONE);
      error    = (state_q == S_ERR);
   end

   // The write strobe and its address/data are registered on the edge taking the 4th byte,
   // so they are presented together for exactly the WRITE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q        <= 16'd0;
         byte_idx_q     <= 2'd0;
         asm_q          <= 24'd0;
         im_we_q        <= 1'b0;
         im_waddr_q     <= 32'd0;
         im_wdata_q     <= 32'd0;
         words_loaded_q <= 16'd0;
      end else begin
         im_we_q <= 1'b0;
         if (start_ok) begin
            words_loaded_q <= 16'd0;
         end
         unique case (state_q)
            S_HDR0: begin
               if (xfer) count_q[15:8] <= in_data;
            end
            S_HDR1: begin
               if (xfer) begin
                  count_q[7:0] <= in_data;
                  byte_idx_q   <= 2'd0;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  asm_q      <= {asm_q[15:0], in_data};
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     im_we_q    <= 1'b1;
                     im_wdata_q <= {asm_q, in_data};
                     im_waddr_q <= BASE_ADDR + 32'({words_loaded_q, 2'b00});
                  end
               end
            end
            S_WRITE: begin
               words_loaded_q <= words_next;
            end
            default: ;
         endcase
      end
   end

   assign im_we        = im_we_q;
   assign im_waddr     = im_waddr_q;
   assign im_wdata     = im_wdata_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, handshake gaps,
// boundary counts, restart/ignore behaviour and reset during a load.
`timescale 1ns/1ps

module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [31:0] im_waddr;
   logic [31:0] im_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_waddr     (im_waddr),
      .im_wdata     (im_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Write log sampled mid-cycle, one entry per strobed cycle.
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         wr_addr.push_back(im_waddr);
         wr_data.push_back(im_wdata);
      end
   end

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, 8'h5A, b ^ 8'h3C};
   endfunction

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         total_cnt++;
         $display("FAIL send_timeout: in_ready=%b, required 1 (byte %h)", in_ready, b);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b, input int gap);
      send_byte(b);
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [15:0] cnt, input int gap);
      send_gap(cnt[15:8], gap);
      send_gap(cnt[7:0], gap);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_gap(w[31:24], gap);
      send_gap(w[23:16], gap);
      send_gap(w[15:8], gap);
      send_gap(w[7:0], gap);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (im_we !== 1'b0)        $display("FAIL rst_im_we: got %b exp 0", im_we); else pass_cnt++;
      total_cnt++; if (cpu_hold !== 1'b1)     $display("FAIL rst_cpu_hold: got %b exp 1", cpu_hold); else pass_cnt++;
      total_cnt++; if (done !== 1'b0)         $display("FAIL rst_done: got %b exp 0", done); else pass_cnt++;
      total_cnt++; if (error !== 1'b0)        $display("FAIL rst_error: got %b exp 0", error); else pass_cnt++;
      total_cnt++; if (words_loaded !== 16'd0) $display("FAIL rst_words: got %0d exp 0", words_loaded); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0)     $display("FAIL rst_in_ready: got %b exp 0", in_ready); else pass_cnt++;
      total_cnt++; if ({im_waddr, im_wdata} !== 64'd0) $display("FAIL rst_addr_data: got %h/%h exp 0/0", im_waddr, im_wdata); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      clear_log();
      pulse_start();
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL nom_hdr_ready: got %b exp 1", in_ready); else pass_cnt++;
      send_hdr(16'h0002, 0);
      send_word(32'h20080005, 0);
      total_cnt++; if (im_we !== 1'b1) $display("FAIL nom_we0: got %b exp 1", im_we); else pass_cnt++;
      total_cnt++; if (im_waddr !== 32'h0) $display("FAIL nom_addr0: got %h exp 00000000", im_waddr); else pass_cnt++;
      total_cnt++; if (im_wdata !== 32'h20080005) $display("FAIL nom_data0: got %h exp 20080005", im_wdata); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL nom_write_ready: got %b exp 0", in_ready); else pass_cnt++;
      // Offer the next byte during WRITE; it must wait for DATA.
      in_valid = 1'b1;
      in_data  = 8'hAC;
      @(negedge clk);
      total_cnt++; if (im_we !== 1'b0) $display("FAIL nom_we0_fall: got %b exp 0", im_we); else pass_cnt++;
      total_cnt++; if (words_loaded !== 16'd1) $display("FAIL nom_words1: got %0d exp 1", words_loaded); else pass_cnt++;
      total_cnt++; if (im_waddr !== 32'h0) $display("FAIL nom_addr_hold: got %h exp 00000000", im_waddr); else pass_cnt++;
      send_word(32'hAC080004, 0);
      total_cnt++; if (im_we !== 1'b1) $display("FAIL nom_we1: got %b exp 1", im_we); else pass_cnt++;
      total_cnt++; if (cpu_hold !== 1'b1) $display("FAIL nom_hold_in_write: got %b exp 1", cpu_hold); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (im_we !== 1'b0) $display("FAIL nom_we1_fall: got %b exp 0", im_we); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL nom_done: got %b exp 1", done); else pass_cnt++;
      total_cnt++; if (cpu_hold !== 1'b0) $display("FAIL nom_cpu_hold: got %b exp 0", cpu_hold); else pass_cnt++;
      total_cnt++; if (words_loaded !== 16'd2) $display("FAIL nom_words2: got %0d exp 2", words_loaded); else pass_cnt++;
      total_cnt++; if (wr_addr.size() !== 2) $display("FAIL nom_wr_count: got %0d exp 2", wr_addr.size()); else pass_cnt++;
      if (wr_addr.size() == 2) begin
         total_cnt++; if ({wr_addr[1], wr_data[1]} !== {32'h4, 32'hAC080004})
            $display("FAIL nom_wr1: got %h/%h exp 00000004/ac080004", wr_addr[1], wr_data[1]); else pass_cnt++;
      end
   endtask

   task automatic test_gaps();
      clear_log();
      pulse_start();
      total_cnt++; if (words_loaded !== 16'd0) $display("FAIL gap_words_clr: got %0d exp 0", words_loaded); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL gap_done_clr: got %b exp 0", done); else pass_cnt++;
      send_hdr(16'h0002, 3);
      send_word(32'h20080005, 3);
      send_word(32'hAC080004, 3);
      total_cnt++; if (wr_addr.size() !== 2) $display("FAIL gap_wr_count: got %0d exp 2", wr_addr.size()); else pass_cnt++;
      if (wr_addr.size() == 2) begin
         total_cnt++; if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {32'h0, 32'h20080005, 32'h4, 32'hAC080004})
            $display("FAIL gap_wr: got %h/%h %h/%h exp 0/20080005 4/ac080004", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]); else pass_cnt++;
      end
      total_cnt++; if ({done, cpu_hold, words_loaded} !== {1'b1, 1'b0, 16'd2})
         $display("FAIL gap_final: got done=%b hold=%b words=%0d exp 1 0 2", done, cpu_hold, words_loaded); else pass_cnt++;
   endtask

   task automatic test_zero_count();
      clear_log();
      pulse_start();
      send_hdr(16'h0000, 0);
      total_cnt++; if ({done, cpu_hold, in_ready} !== 3'b100)
         $display("FAIL zero_state: got done=%b hold=%b ready=%b exp 1 0 0", done, cpu_hold, in_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wr_addr.size() !== 0) $display("FAIL zero_no_writes: got %0d exp 0", wr_addr.size()); else pass_cnt++;
      total_cnt++; if (words_loaded !== 16'd0) $display("FAIL zero_words: got %0d exp 0", words_loaded); else pass_cnt++;
   endtask

   task automatic test_overflow();
      clear_log();
      pulse_start();
      send_hdr(16'h0041, 0);
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (error !== 1'b1) $display("FAIL ovf_error: got %b exp 1", error); else pass_cnt++;
      total_cnt++; if ({cpu_hold, in_ready, done} !== 3'b100)
         $display("FAIL ovf_state: got hold=%b ready=%b done=%b exp 1 0 0", cpu_hold, in_ready, done); else pass_cnt++;
      total_cnt++; if (wr_addr.size() !== 0) $display("FAIL ovf_no_writes: got %0d exp 0", wr_addr.size()); else pass_cnt++;
      pulse_start();
      total_cnt++; if ({error, in_ready, cpu_hold} !== 3'b011)
         $display("FAIL err_exit: got error=%b ready=%b hold=%b exp 0 1 1", error, in_ready, cpu_hold); else pass_cnt++;
   endtask

   // Entered in HDR0 straight after leaving ERR.
   task automatic test_full_depth();
      int bad;
      clear_log();
      send_hdr(16'h0040, 0);
      for (int i = 0; i < 64; i++) send_word(pat(i), 0);
      @(negedge clk);
      total_cnt++; if (wr_addr.size() !== 64) $display("FAIL full_wr_count: got %0d exp 64", wr_addr.size()); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
         if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== pat(i)) bad++;
      end
      total_cnt++; if (bad !== 0) $display("FAIL full_contents: got %0d bad words exp 0", bad); else pass_cnt++;
      total_cnt++; if (im_waddr !== 32'hFC) $display("FAIL full_last_addr: got %h exp 000000fc", im_waddr); else pass_cnt++;
      total_cnt++; if ({done, cpu_hold, words_loaded} !== {1'b1, 1'b0, 16'd64})
         $display("FAIL full_final: got done=%b hold=%b words=%0d exp 1 0 64", done, cpu_hold, words_loaded); else pass_cnt++;
   endtask

   task automatic test_restart_ignore();
      clear_log();
      pulse_start();
      total_cnt++; if ({done, cpu_hold, words_loaded} !== {1'b0, 1'b1, 16'd0})
         $display("FAIL rs_clear: got done=%b hold=%b words=%0d exp 0 1 0", done, cpu_hold, words_loaded); else pass_cnt++;
      send_hdr(16'h0001, 0);
      send_byte(8'h11);
      send_byte(8'h22);
      pulse_start();
      send_byte(8'h33);
      send_byte(8'h44);
      total_cnt++; if ({im_we, cpu_hold} !== 2'b11)
         $display("FAIL rs_write: got we=%b hold=%b exp 1 1", im_we, cpu_hold); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({done, cpu_hold, words_loaded} !== {1'b1, 1'b0, 16'd1})
         $display("FAIL rs_final: got done=%b hold=%b words=%0d exp 1 0 1", done, cpu_hold, words_loaded); else pass_cnt++;
      total_cnt++; if (wr_data.size() !== 1) $display("FAIL rs_wr_count: got %0d exp 1", wr_data.size()); else pass_cnt++;
      if (wr_data.size() == 1) begin
         total_cnt++; if ({wr_addr[0], wr_data[0]} !== {32'h0, 32'h11223344})
            $display("FAIL rs_wr: got %h/%h exp 00000000/11223344", wr_addr[0], wr_data[0]); else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      pulse_start();
      send_hdr(16'h0003, 0);
      send_word(32'h20080005, 0);
      send_byte(8'hAA);
      send_byte(8'hBB);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if ({im_we, cpu_hold, in_ready, words_loaded} !== {1'b0, 1'b1, 1'b0, 16'd0})
         $display("FAIL rm_reset: got we=%b hold=%b ready=%b words=%0d exp 0 1 0 0", im_we, cpu_hold, in_ready, words_loaded); else pass_cnt++;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hCC;
      repeat (6) @(negedge clk);
      in_valid = 1'b0;
      total_cnt++; if (wr_addr.size() !== 1) $display("FAIL rm_no_more_writes: got %0d exp 1", wr_addr.size()); else pass_cnt++;
      total_cnt++; if ({in_ready, cpu_hold, done} !== 3'b010)
         $display("FAIL rm_idle: got ready=%b hold=%b done=%b exp 0 1 0", in_ready, cpu_hold, done); else pass_cnt++;
      pulse_start();
      send_hdr(16'h0002, 0);
      send_word(32'h20080005, 0);
      send_word(32'hAC080004, 0);
      @(negedge clk);
      total_cnt++; if ({done, words_loaded} !== {1'b1, 16'd2})
         $display("FAIL rm_reload: got done=%b words=%0d exp 1 2", done, words_loaded); else pass_cnt++;
      total_cnt++; if (wr_addr.size() !== 3) $display("FAIL rm_wr_count: got %0d exp 3", wr_addr.size()); else pass_cnt++;
      if (wr_addr.size() == 3) begin
         total_cnt++; if ({wr_addr[2], wr_data[2]} !== {32'h4, 32'hAC080004})
            $display("FAIL rm_wr_last: got %h/%h exp 00000004/ac080004", wr_addr[2], wr_data[2]); else pass_cnt++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_gaps();
      test_zero_count();
      test_overflow();
      test_full_depth();
      test_restart_ignore();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
